// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
//
// UART receive path. Oversamples the serial line PRESCALE times per bit,
// detects the start bit, shifts in DATA_WIDTH payload bits LSB first, checks an
// optional parity bit and one stop bit, then presents the payload with a
// one-cycle valid strobe. Frames with a parity or stop error are dropped and
// flagged with one-cycle error strobes instead.
//
// Parameters:
//   DATA_WIDTH  payload bits per frame (>= 2)
//   PRESCALE    clock cycles per bit (even, >= 4)
//
// Ports:
//   CLK         system clock, rising edge
//   RST         asynchronous active-low reset
//   RX_IN       serial line, idle high, asynchronous to CLK
//   PAR_EN      1 = frame carries a parity bit (latched at start of frame)
//   PAR_TYP     0 = even, 1 = odd parity (latched at start of frame)
//   P_DATA      last correctly received payload
//   DATA_VALID  one-cycle pulse: P_DATA updated
//   PAR_ERR     one-cycle pulse: parity mismatch, frame dropped
//   STP_ERR     one-cycle pulse: stop bit sampled 0, frame dropped
// -----------------------------------------------------------------------------
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    // Sample points within one bit period.
    localparam logic [EW-1:0] SAMP0_PT = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] SAMP1_PT = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] RES_PT   = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] END_PT   = EW'(PRESCALE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state;
    logic                    rx_meta;
    logic                    rx_s;
    logic [EW-1:0]           edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic                    samp0;
    logic                    samp1;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    par_en_l;
    logic                    par_typ_l;
    logic                    par_acc;
    logic                    par_bad;
    logic                    armed;
    logic                    maj;
    logic                    at_res;
    logic                    at_end;

    // Two-flop synchronizer for the asynchronous serial line.
    // NOTE: the synchronizer resets to 1 so the line reads idle out of reset and
    // cannot fake a start bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make rx_s take the old rx_meta,
            // giving two real flop stages rather than a wire.
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // The third sample is the live rx_s on the resolve cycle itself.
    assign maj    = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);
    assign at_res = (edge_cnt == RES_PT);
    assign at_end = (edge_cnt == END_PT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            samp0      <= 1'b1;
            samp1      <= 1'b1;
            shreg      <= '0;
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            par_acc    <= 1'b0;
            par_bad    <= 1'b0;
            armed      <= 1'b1;
            P_DATA     <= '0;
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            PAR_ERR    <= 1'b0;
            STP_ERR    <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= at_end ? '0 : edge_cnt + EW'(1);
                if (edge_cnt == SAMP0_PT) samp0 <= rx_s;
                if (edge_cnt == SAMP1_PT) samp1 <= rx_s;
            end

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        // This cycle is edge_cnt = 0 of the start bit.
                        state     <= START;
                        edge_cnt  <= EW'(1);
                        bit_cnt   <= '0;
                        par_en_l  <= PAR_EN;
                        par_typ_l <= PAR_TYP;
                        par_acc   <= 1'b0;
                        par_bad   <= 1'b0;
                    end
                end

                START: begin
                    if (at_res && maj) begin
                        // Start bit did not hold low: glitch, drop silently.
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (at_end) begin
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (at_res) begin
                        shreg   <= {maj, shreg[DATA_WIDTH-1:1]};
                        par_acc <= par_acc ^ maj;
                    end
                    if (at_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end

                PARITY: begin
                    if (at_res) par_bad <= (maj != (par_acc ^ par_typ_l));
                    if (at_end) state <= STOP;
                end

                STOP: begin
                    // Leave early so the second half of the stop bit can
                    // catch a back-to-back start edge.
                    if (at_res) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        PAR_ERR  <= par_bad;
                        STP_ERR  <= ~maj;
                        // A low stop bit disarms start detection until the
                        // line has been seen high again.
                        armed    <= maj;
                        if (!par_bad && maj) begin
                            P_DATA     <= shreg;
                            DATA_VALID <= 1'b1;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deserializer
//
// Directed self-checking bench for uart_rx_deserializer with default
// parameters. Frames are driven bit by bit; a negedge monitor counts the
// output strobes and records when and with what data DATA_VALID fires.
// -----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    localparam int DW = 8;
    localparam int P  = 8;

    logic          CLK;
    logic          RST;
    logic          RX_IN;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_ERR;
    logic          STP_ERR;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int dv_cnt   = 0;
    int par_cnt  = 0;
    int stp_cnt  = 0;
    int long_cnt = 0;
    int frame_start;
    int dv_cyc_q[$];
    logic [DW-1:0] dv_data_q[$];
    logic dv_prev, pe_prev, se_prev;

    uart_rx_deserializer #(
        .DATA_WIDTH(DW),
        .PRESCALE  (P)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RX_IN     (RX_IN),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_ERR   (PAR_ERR),
        .STP_ERR   (STP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe monitor, sampled away from the active edge.
    initial begin
        dv_prev = 1'b0;
        pe_prev = 1'b0;
        se_prev = 1'b0;
    end
    always @(negedge CLK) begin
        if (DATA_VALID === 1'b1) begin
            dv_cnt++;
            dv_cyc_q.push_back(cyc);
            dv_data_q.push_back(P_DATA);
        end
        if (PAR_ERR === 1'b1) par_cnt++;
        if (STP_ERR === 1'b1) stp_cnt++;
        if ((DATA_VALID === 1'b1 && dv_prev) || (PAR_ERR === 1'b1 && pe_prev) ||
            (STP_ERR === 1'b1 && se_prev))
            long_cnt++;
        dv_prev = (DATA_VALID === 1'b1);
        pe_prev = (PAR_ERR === 1'b1);
        se_prev = (STP_ERR === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        RX_IN = b;
        repeat (P) tick();
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic has_par,
                              input logic par_bit, input logic stop_bit);
        frame_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (has_par) send_bit(par_bit);
        send_bit(stop_bit);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] aborted;
        RST     = 1'b0;
        RX_IN   = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_p_data", 32'(P_DATA), 32'h0);
        check("reset_strobes", {29'b0, DATA_VALID, PAR_ERR, STP_ERR}, 32'h0);
        tick();
        RST = 1'b1;
        idle(4);

        // No parity, 0xA5, latency 80 cycles from the start edge.
        dv_cyc_q.delete();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("a5_dv_cnt", 32'(dv_cnt), 32'd1);
        check("a5_data", 32'(P_DATA), 32'hA5);
        check("a5_no_err", 32'(par_cnt + stp_cnt), 32'd0);
        check("a5_latency", 32'((dv_cyc_q.size() > 0) ? dv_cyc_q[0] - frame_start : -1), 32'd80);

        // Even parity: good then bad parity bit for 0x37.
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        send_frame(8'h37, 1'b1, 1'b1, 1'b1);
        idle(8);
        check("even_ok_dv", 32'(dv_cnt), 32'd2);
        check("even_ok_data", 32'(P_DATA), 32'h37);
        send_frame(8'h37, 1'b1, 1'b0, 1'b1);
        idle(8);
        check("even_bad_par_err", 32'(par_cnt), 32'd1);
        check("even_bad_no_dv", 32'(dv_cnt), 32'd2);
        check("even_bad_keep_data", 32'(P_DATA), 32'h37);
        check("even_bad_no_stp", 32'(stp_cnt), 32'd0);

        // Odd parity: 0x00 valid, then 0xFF with a low stop bit held low.
        PAR_TYP = 1'b1;
        send_frame(8'h00, 1'b1, 1'b1, 1'b1);
        idle(8);
        check("odd_ok_dv", 32'(dv_cnt), 32'd3);
        check("odd_ok_data", 32'(P_DATA), 32'h00);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
        repeat (3 * P) tick();
        idle(12 * P);
        check("stop_err_stp", 32'(stp_cnt), 32'd1);
        check("stop_err_par", 32'(par_cnt), 32'd1);
        check("stop_err_no_dv", 32'(dv_cnt), 32'd3);
        check("stop_err_keep_data", 32'(P_DATA), 32'h00);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        idle(8);
        check("after_stp_dv", 32'(dv_cnt), 32'd4);
        check("after_stp_data", 32'(P_DATA), 32'h5A);

        // Two-cycle low glitch on idle line, then 0xC3.
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        RX_IN   = 1'b0;
        tick();
        tick();
        idle(3 * P);
        check("glitch_no_strobe", 32'(dv_cnt + par_cnt + stp_cnt), 32'd6);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("glitch_next_dv", 32'(dv_cnt), 32'd5);
        check("glitch_next_data", 32'(P_DATA), 32'hC3);

        // Three back-to-back frames with no idle time.
        dv_cyc_q.delete();
        dv_data_q.delete();
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("b2b_count", 32'(dv_cyc_q.size()), 32'd3);
        if (dv_cyc_q.size() == 3) begin
            check("b2b_gap1", 32'(dv_cyc_q[1] - dv_cyc_q[0]), 32'(10 * P));
            check("b2b_gap2", 32'(dv_cyc_q[2] - dv_cyc_q[1]), 32'(10 * P));
            check("b2b_data0", 32'(dv_data_q[0]), 32'h01);
            check("b2b_data1", 32'(dv_data_q[1]), 32'h80);
            check("b2b_data2", 32'(dv_data_q[2]), 32'h7E);
        end

        // Reset in the middle of the data bits of 0x96, then 0x69.
        aborted = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(aborted[i]);
        RST = 1'b0;
        tick();
        tick();
        @(negedge CLK);
        check("midrst_p_data", 32'(P_DATA), 32'h0);
        check("midrst_strobes", {29'b0, DATA_VALID, PAR_ERR, STP_ERR}, 32'h0);
        RX_IN = 1'b1;
        tick();
        RST = 1'b1;
        idle(12 * P);
        check("midrst_no_strobe", 32'(dv_cnt + par_cnt + stp_cnt), 32'd10);
        send_frame(8'h69, 1'b0, 1'b0, 1'b1);
        idle(8);
        check("midrst_next_dv", 32'(dv_cnt), 32'd9);
        check("midrst_next_data", 32'(P_DATA), 32'h69);

        check("strobes_single_cycle", 32'(long_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
